// File: rtl/mbscore_ctrl_mc.sv
// Multicycle IF/ID/EXE/MEM/WB control FSM for MBScore with imem/dmem handshakes, wait timeout and pause.
// Latency: 2-4 state cycles per instruction plus memory wait states; strobes are combinational from state and IR.
// Backpressure: imem_req/dmem_req held until ready; stop/pause drop requests; bus_err after 2**TMO_W-1 waits.
module mbscore_ctrl_mc #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int IMM_WIDTH      = 16,
    parameter int ALU_OP_WIDTH   = 4,
    parameter int ALU_SEL_WIDTH  = 2,
    parameter int TMO_W          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stop,
    input  logic                      pause,
    input  logic [DATA_WIDTH-1:0]     imem_rdata,
    input  logic                      imem_ready,
    input  logic                      dmem_ready,
    output logic                      imem_req,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [DATA_WIDTH-1:0]     inst,
    output logic [REG_ADDR_WIDTH-1:0] rs_addr,
    output logic [REG_ADDR_WIDTH-1:0] rt_addr,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [IMM_WIDTH-1:0]      imm,
    output logic [ALU_SEL_WIDTH-1:0]  alu_sel_a,
    output logic [ALU_SEL_WIDTH-1:0]  alu_sel_b,
    output logic [ALU_OP_WIDTH-1:0]   alu_op_type,
    output logic                      reg_we,
    output logic                      pc_we,
    output logic                      mem_to_reg_we,
    output logic                      lui,
    output logic                      spr_sel,
    output logic                      jump,
    output logic                      branch,
    output logic                      jr,
    output logic                      hlt,
    output logic                      syscall,
    output logic                      next,
    output logic                      bus_err,
    output logic [3:0]                state
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_IF    = 4'd1;
    localparam logic [3:0] S_ID    = 4'd2;
    localparam logic [3:0] S_EXE   = 4'd3;
    localparam logic [3:0] S_MEM   = 4'd4;
    localparam logic [3:0] S_WB    = 4'd5;
    localparam logic [3:0] S_PAUSE = 4'd6;
    localparam logic [3:0] S_HALT  = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SPRWR = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    localparam logic [5:0] F_SLL     = 6'h00;
    localparam logic [5:0] F_SRL     = 6'h02;
    localparam logic [5:0] F_SRA     = 6'h03;
    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_SYSCALL = 6'h0C;
    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_ADDU    = 6'h21;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_SUBU    = 6'h23;
    localparam logic [5:0] F_AND     = 6'h24;
    localparam logic [5:0] F_OR      = 6'h25;
    localparam logic [5:0] F_XOR     = 6'h26;
    localparam logic [5:0] F_NOR     = 6'h27;
    localparam logic [5:0] F_SLT     = 6'h2A;
    localparam logic [5:0] F_SLTU    = 6'h2B;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADDU = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUBU = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOR  = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = ALU_OP_WIDTH'(10);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = ALU_OP_WIDTH'(11);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = ALU_OP_WIDTH'(12);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LUI  = ALU_OP_WIDTH'(13);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP  = ALU_OP_WIDTH'(15);

    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SEL_RS  = ALU_SEL_WIDTH'(0);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SEL_RT  = ALU_SEL_WIDTH'(1);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SEL_IMM = ALU_SEL_WIDTH'(2);
    localparam logic [ALU_SEL_WIDTH-1:0] ALU_SEL_PC  = ALU_SEL_WIDTH'(3);

    // Instruction classes; everything unrecognised falls into C_NOP.
    typedef enum logic [3:0] {
        C_NOP, C_RALU, C_SHIFT, C_IALU, C_LUI, C_LW, C_SW, C_BR,
        C_J, C_JAL, C_JR, C_SYSCALL, C_HLT, C_SPRWR
    } cls_t;

    logic [3:0]              state_q, state_nxt, saved_q;
    logic [TMO_W-1:0]        tmo_q;
    logic [DATA_WIDTH-1:0]   ir_q;
    cls_t                    cls;
    logic [ALU_OP_WIDTH-1:0] dec_op;
    logic [ALU_SEL_WIDTH-1:0] dec_sel_a, dec_sel_b;
    logic [5:0]              opcode, funct;
    logic                    run, waiting, tmo_done, tmo_clr, tmo_inc;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];

    // A cycle only advances the instruction when neither stop nor pause overrides it.
    assign run      = !stop && !pause;
    assign waiting  = (state_q == S_IF && !imem_ready) || (state_q == S_MEM && !dmem_ready);
    assign tmo_done = &tmo_q;
    // Returning from PAUSE keeps the partially elapsed wait budget.
    assign tmo_clr  = (state_nxt != state_q) && (state_q != S_PAUSE) &&
                      (state_nxt == S_IF || state_nxt == S_MEM);
    assign tmo_inc  = run && waiting && !tmo_done;

    // State, resume point and wait-timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            saved_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_nxt;
            if (!stop && pause && state_q != S_PAUSE && state_q != S_HALT)
                saved_q <= state_q;
            if (tmo_clr)
                tmo_q <= '0;
            else if (tmo_inc)
                tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    // Instruction register loads only on a fetch that is allowed to complete.
    always_ff @(posedge clk) begin
        if (rst)
            ir_q <= '0;
        else if (state_q == S_IF && imem_ready && run)
            ir_q <= imem_rdata;
    end

    // Classify the IR and pick its ALU operation and operand selects.
    always_comb begin
        cls       = C_NOP;
        dec_op    = ALU_OP_NOP;
        dec_sel_a = ALU_SEL_RS;
        dec_sel_b = ALU_SEL_RT;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_SLL:     begin cls = C_SHIFT; dec_op = ALU_OP_SLL;  end
                    F_SRL:     begin cls = C_SHIFT; dec_op = ALU_OP_SRL;  end
                    F_SRA:     begin cls = C_SHIFT; dec_op = ALU_OP_SRA;  end
                    F_JR:      cls = C_JR;
                    F_SYSCALL: cls = C_SYSCALL;
                    F_ADD:     begin cls = C_RALU; dec_op = ALU_OP_ADD;  end
                    F_ADDU:    begin cls = C_RALU; dec_op = ALU_OP_ADDU; end
                    F_SUB:     begin cls = C_RALU; dec_op = ALU_OP_SUB;  end
                    F_SUBU:    begin cls = C_RALU; dec_op = ALU_OP_SUBU; end
                    F_AND:     begin cls = C_RALU; dec_op = ALU_OP_AND;  end
                    F_OR:      begin cls = C_RALU; dec_op = ALU_OP_OR;   end
                    F_XOR:     begin cls = C_RALU; dec_op = ALU_OP_XOR;  end
                    F_NOR:     begin cls = C_RALU; dec_op = ALU_OP_NOR;  end
                    F_SLT:     begin cls = C_RALU; dec_op = ALU_OP_SLT;  end
                    F_SLTU:    begin cls = C_RALU; dec_op = ALU_OP_SLTU; end
                    default:   cls = C_NOP;
                endcase
            end
            OP_J:     cls = C_J;
            OP_JAL:   begin cls = C_JAL; dec_op = ALU_OP_ADD; end
            OP_BEQ, OP_BNE: begin cls = C_BR; dec_op = ALU_OP_SUB; end
            OP_ADDI:  begin cls = C_IALU; dec_op = ALU_OP_ADD;  end
            OP_ADDIU: begin cls = C_IALU; dec_op = ALU_OP_ADDU; end
            OP_SLTI:  begin cls = C_IALU; dec_op = ALU_OP_SLT;  end
            OP_SLTIU: begin cls = C_IALU; dec_op = ALU_OP_SLTU; end
            OP_ANDI:  begin cls = C_IALU; dec_op = ALU_OP_AND;  end
            OP_ORI:   begin cls = C_IALU; dec_op = ALU_OP_OR;   end
            OP_XORI:  begin cls = C_IALU; dec_op = ALU_OP_XOR;  end
            OP_LUI:   begin cls = C_LUI;  dec_op = ALU_OP_LUI;  end
            OP_SPRWR: cls = C_SPRWR;
            OP_LW:    begin cls = C_LW; dec_op = ALU_OP_ADD; end
            OP_SW:    begin cls = C_SW; dec_op = ALU_OP_ADD; end
            OP_HLT:   cls = C_HLT;
            default:  cls = C_NOP;
        endcase
        case (cls)
            C_SHIFT:                  dec_sel_a = ALU_SEL_IMM;
            C_IALU, C_LUI, C_LW, C_SW: dec_sel_b = ALU_SEL_IMM;
            C_JAL: begin
                dec_sel_a = ALU_SEL_PC;
                dec_sel_b = ALU_SEL_IMM;
            end
            default: ;
        endcase
    end

    // Next state: rst (in the register) > stop > pause > normal sequencing.
    always_comb begin
        state_nxt = state_q;
        if (stop) begin
            state_nxt = S_IDLE;
        end else if (pause && state_q != S_HALT) begin
            state_nxt = S_PAUSE;
        end else begin
            case (state_q)
                S_IDLE: state_nxt = S_IF;
                S_IF: begin
                    if (imem_ready)    state_nxt = S_ID;
                    else if (tmo_done) state_nxt = S_IDLE;
                end
                S_ID: begin
                    if (cls == C_J || cls == C_SYSCALL) state_nxt = S_IF;
                    else if (cls == C_HLT)              state_nxt = S_HALT;
                    else                                state_nxt = S_EXE;
                end
                S_EXE: begin
                    if (cls == C_JR || cls == C_JAL || cls == C_SPRWR) state_nxt = S_IF;
                    else if (cls == C_LW || cls == C_SW)               state_nxt = S_MEM;
                    else                                               state_nxt = S_WB;
                end
                S_MEM: begin
                    if (dmem_ready)    state_nxt = S_IF;
                    else if (tmo_done) state_nxt = S_IDLE;
                end
                S_WB:    state_nxt = S_IF;
                S_PAUSE: state_nxt = saved_q;
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs: IR fields everywhere but HALT, strobes only in the state that owns them.
    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        inst          = '0;
        rs_addr       = '0;
        rt_addr       = '0;
        rd_addr       = '0;
        imm           = '0;
        alu_sel_a     = '0;
        alu_sel_b     = '0;
        alu_op_type   = '0;
        reg_we        = 1'b0;
        pc_we         = 1'b0;
        mem_to_reg_we = 1'b0;
        lui           = 1'b0;
        spr_sel       = 1'b0;
        jump          = 1'b0;
        branch        = 1'b0;
        jr            = 1'b0;
        hlt           = 1'b0;
        syscall       = 1'b0;
        next          = 1'b0;
        bus_err       = 1'b0;
        state         = state_q;
        if (state_q != S_HALT) begin
            inst    = ir_q;
            rs_addr = REG_ADDR_WIDTH'(ir_q[25:21]);
            rt_addr = REG_ADDR_WIDTH'(ir_q[20:16]);
            if (cls == C_JAL)          rd_addr = {REG_ADDR_WIDTH{1'b1}};
            else if (opcode == OP_RTYPE) rd_addr = REG_ADDR_WIDTH'(ir_q[15:11]);
            else                       rd_addr = REG_ADDR_WIDTH'(ir_q[20:16]);
            if (cls == C_SHIFT) imm = IMM_WIDTH'(ir_q[10:6]);
            else                imm = IMM_WIDTH'(ir_q[15:0]);
        end
        case (state_q)
            S_IF: begin
                imem_req = run;
                pc_we    = run && imem_ready;
                bus_err  = run && !imem_ready && tmo_done;
            end
            S_ID: begin
                alu_sel_a = dec_sel_a;
                alu_sel_b = dec_sel_b;
                if (run) begin
                    jump    = (cls == C_J);
                    syscall = (cls == C_SYSCALL);
                    hlt     = (cls == C_HLT);
                    next    = (cls == C_J) || (cls == C_SYSCALL) || (cls == C_HLT);
                end
            end
            S_EXE: begin
                alu_sel_a   = dec_sel_a;
                alu_sel_b   = dec_sel_b;
                alu_op_type = dec_op;
                if (run) begin
                    jr      = (cls == C_JR);
                    jump    = (cls == C_JAL);
                    reg_we  = (cls == C_JAL);
                    spr_sel = (cls == C_SPRWR);
                    next    = (cls == C_JR) || (cls == C_JAL) || (cls == C_SPRWR);
                end
            end
            S_MEM: begin
                dmem_req = run;
                dmem_we  = run && (cls == C_SW);
                if (run && dmem_ready) begin
                    next          = 1'b1;
                    mem_to_reg_we = (cls == C_LW);
                end
                bus_err = run && !dmem_ready && tmo_done;
            end
            S_WB: begin
                if (run) begin
                    branch = (cls == C_BR);
                    reg_we = (cls != C_BR) && (cls != C_NOP);
                    lui    = (cls == C_LUI);
                    next   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mbscore_ctrl_mc.sv
module tb_mbscore_ctrl_mc;

    localparam logic [3:0] S_IDLE = 4'd0, S_IF = 4'd1, S_ID = 4'd2, S_EXE = 4'd3,
                           S_MEM = 4'd4, S_WB = 4'd5, S_PAUSE = 4'd6, S_HALT = 4'd7;
    localparam logic [8:0] B_REG = 9'h100, B_M2R = 9'h080, B_LUI = 9'h040, B_JMP = 9'h020,
                           B_BR = 9'h010, B_JR = 9'h008, B_HLT = 9'h004, B_SYS = 9'h002,
                           B_SPR = 9'h001;
    localparam logic [31:0] I_ADDU = 32'h0022_1821, I_LW = 32'h8C25_0004,
                            I_SW = 32'hAC25_0008, I_HLT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst, stop, pause, imem_ready, dmem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req, dmem_req, dmem_we;
    logic [31:0] inst;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [15:0] imm;
    logic [1:0]  alu_sel_a, alu_sel_b;
    logic [3:0]  alu_op_type, state;
    logic        reg_we, pc_we, mem_to_reg_we, lui, spr_sel, jump, branch, jr, hlt, syscall;
    logic        next, bus_err;
    logic [8:0]  strb;
    logic [85:0] all_outs;

    always #5 clk = ~clk;

    mbscore_ctrl_mc dut (
        .clk(clk), .rst(rst), .stop(stop), .pause(pause),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .inst(inst),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm),
        .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b), .alu_op_type(alu_op_type),
        .reg_we(reg_we), .pc_we(pc_we), .mem_to_reg_we(mem_to_reg_we), .lui(lui),
        .spr_sel(spr_sel), .jump(jump), .branch(branch), .jr(jr), .hlt(hlt),
        .syscall(syscall), .next(next), .bus_err(bus_err), .state(state)
    );

    assign strb = {reg_we, mem_to_reg_we, lui, jump, branch, jr, hlt, syscall, spr_sel};
    assign all_outs = {imem_req, dmem_req, dmem_we, inst, rs_addr, rt_addr, rd_addr, imm,
                       alu_sel_a, alu_sel_b, alu_op_type, reg_we, pc_we, mem_to_reg_we, lui,
                       spr_sel, jump, branch, jr, hlt, syscall, next, bus_err};

    typedef struct {
        int          id;
        logic [31:0] ins;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [3:0]  aop;
        logic [3:0]  ret_st;
        logic [8:0]  strb;
        int          ncyc;
    } vec_t;

    vec_t tbl[13];
    vec_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [3:0] s);
        bit hit = 0;
        for (int n = 0; n < 10 && !hit; n++) begin
            if (state == s) hit = 1;
            else cyc();
        end
        chk("reach_state", 32'(state), 32'(s));
    endtask

    function automatic vec_t mk(input int id, input logic [31:0] ins, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] im,
                                input logic [3:0] aop, input logic [3:0] st, input logic [8:0] sb_,
                                input int n);
        vec_t v;
        v.id = id; v.ins = ins; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = im;
        v.aop = aop; v.ret_st = st; v.strb = sb_; v.ncyc = n;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        bit   done;
        rst = 1; stop = 0; pause = 0; imem_ready = 0; dmem_ready = 0; imem_rdata = '0;

        tbl[0]  = mk(0,  I_ADDU,        5'd1,  5'd2, 5'd3,  16'h1821, 4'd1,  S_WB,  B_REG,         3);
        tbl[1]  = mk(1,  32'h0005_20C0, 5'd0,  5'd5, 5'd4,  16'h0003, 4'd10, S_WB,  B_REG,         3);
        tbl[2]  = mk(2,  32'h24E6_0010, 5'd7,  5'd6, 5'd6,  16'h0010, 4'd1,  S_WB,  B_REG,         3);
        tbl[3]  = mk(3,  32'h3C08_1234, 5'd0,  5'd8, 5'd8,  16'h1234, 4'd13, S_WB,  B_REG | B_LUI, 3);
        tbl[4]  = mk(4,  I_LW,          5'd1,  5'd5, 5'd5,  16'h0004, 4'd0,  S_MEM, B_M2R,         3);
        tbl[5]  = mk(5,  I_SW,          5'd1,  5'd5, 5'd5,  16'h0008, 4'd0,  S_MEM, 9'h000,        3);
        tbl[6]  = mk(6,  32'h1022_0003, 5'd1,  5'd2, 5'd2,  16'h0003, 4'd2,  S_WB,  B_BR,          3);
        tbl[7]  = mk(7,  32'h0800_0010, 5'd0,  5'd0, 5'd0,  16'h0010, 4'd15, S_ID,  B_JMP,         1);
        tbl[8]  = mk(8,  32'h03E0_0008, 5'd31, 5'd0, 5'd0,  16'h0008, 4'd15, S_EXE, B_JR,          2);
        tbl[9]  = mk(9,  32'h0C00_0020, 5'd0,  5'd0, 5'd31, 16'h0020, 4'd0,  S_EXE, B_JMP | B_REG, 2);
        tbl[10] = mk(10, 32'h0000_000C, 5'd0,  5'd0, 5'd0,  16'h000C, 4'd15, S_ID,  B_SYS,         1);
        tbl[11] = mk(11, 32'hF800_0000, 5'd0,  5'd0, 5'd0,  16'h0000, 4'd15, S_WB,  9'h000,        3);
        tbl[12] = mk(12, 32'h4000_0000, 5'd0,  5'd0, 5'd0,  16'h0000, 4'd15, S_EXE, B_SPR,         2);

        // Reset held for three cycles, then release into IF.
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_outs_zero", 32'(|all_outs), 32'd0);
        cyc();
        rst = 0;
        @(negedge clk);
        chk("idle_after_rst", 32'(state), 32'(S_IDLE));
        chk("idle_no_req", 32'(imem_req), 32'd0);
        cyc();
        @(negedge clk);
        chk("if_after_rst", 32'(state), 32'(S_IF));
        chk("if_req", 32'(imem_req), 32'd1);
        cyc();

        // Table of instruction classes; retirements scored against the queue.
        for (int i = 0; i < 13; i++) begin
            imem_rdata = tbl[i].ins;
            imem_ready = 1;
            sb.push_back(tbl[i]);
            done = 0;
            for (int k = 0; k < 8 && !done; k++) begin
                dmem_ready = (state == S_MEM);
                @(negedge clk);
                if (k == 0) begin
                    chk("fetch_state", 32'(state), 32'(S_IF));
                    chk("fetch_pc_we", 32'(pc_we), 32'd1);
                end
                if (state == S_ID) begin
                    chk("dec_rs", 32'(rs_addr), 32'(tbl[i].rs));
                    chk("dec_rt", 32'(rt_addr), 32'(tbl[i].rt));
                    chk("dec_rd", 32'(rd_addr), 32'(tbl[i].rd));
                    chk("dec_imm", 32'(imm), 32'(tbl[i].imm));
                end
                if (state == S_EXE)
                    chk("exe_alu_op", 32'(alu_op_type), 32'(tbl[i].aop));
                if (next) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_next", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("ret_state", 32'(state), 32'(e.ret_st));
                        chk("ret_strobes", 32'(strb), 32'(e.strb));
                        chk("ret_cycles", 32'(k), 32'(e.ncyc));
                        chk("ret_inst", inst, e.ins);
                    end
                    done = 1;
                end
                cyc();
                imem_ready = 0;
            end
            dmem_ready = 0;
            if (!done) chk("retire_timeout", 32'd0, 32'd1);
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // LW with three wait states on dmem.
        imem_rdata = I_LW; imem_ready = 1;
        cyc();
        imem_ready = 0;
        go_to(S_MEM);
        for (int k = 0; k < 4; k++) begin
            dmem_ready = (k == 3);
            @(negedge clk);
            chk("lw_dmem_req", 32'(dmem_req), 32'd1);
            chk("lw_dmem_we", 32'(dmem_we), 32'd0);
            chk("lw_m2r", 32'(mem_to_reg_we), 32'(k == 3));
            chk("lw_next", 32'(next), 32'(k == 3));
            cyc();
        end
        dmem_ready = 0;
        chk("lw_back_if", 32'(state), 32'(S_IF));

        // Pause for two cycles during a store's MEM phase.
        imem_rdata = I_SW; imem_ready = 1;
        cyc();
        imem_ready = 0;
        go_to(S_MEM);
        @(negedge clk);
        chk("sw_dmem_we", 32'(dmem_we), 32'd1);
        cyc();
        pause = 1;
        @(negedge clk);
        chk("pause_req_drop", 32'(dmem_req), 32'd0);
        cyc();
        @(negedge clk);
        chk("pause_state", 32'(state), 32'(S_PAUSE));
        chk("pause_req_zero", 32'(dmem_req), 32'd0);
        cyc();
        pause = 0;
        @(negedge clk);
        chk("pause_still", 32'(state), 32'(S_PAUSE));
        cyc();
        dmem_ready = 1;
        @(negedge clk);
        chk("resume_mem", 32'(state), 32'(S_MEM));
        chk("resume_req", 32'(dmem_req), 32'd1);
        chk("resume_next", 32'(next), 32'd1);
        cyc();
        dmem_ready = 0;
        chk("sw_back_if", 32'(state), 32'(S_IF));

        // Fetch timeout: bus_err exactly 15 cycles after entering IF.
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("tmo_bus_err", 32'(bus_err), 32'(k == 15));
            cyc();
        end
        chk("tmo_idle", 32'(state), 32'(S_IDLE));
        cyc();
        // Ready on the terminal-count cycle wins over the timeout.
        imem_rdata = I_ADDU;
        for (int k = 0; k < 16; k++) begin
            imem_ready = (k == 15);
            @(negedge clk);
            if (k == 15) chk("tmo_ready_wins", 32'(bus_err), 32'd0);
            cyc();
        end
        imem_ready = 0;
        chk("tmo_ready_id", 32'(state), 32'(S_ID));
        go_to(S_IF);

        // Pause mid-wait keeps the elapsed count: 10 waits, pause, 5 more waits.
        repeat (10) cyc();
        pause = 1;
        repeat (3) cyc();
        pause = 0;
        cyc();
        chk("pause_if_resume", 32'(state), 32'(S_IF));
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("pause_tmo_err", 32'(bus_err), 32'(j == 5));
            cyc();
        end
        chk("pause_tmo_idle", 32'(state), 32'(S_IDLE));
        cyc();

        // Stop during MEM drops the request and keeps the IR.
        imem_rdata = I_SW; imem_ready = 1;
        cyc();
        imem_ready = 0;
        go_to(S_MEM);
        stop = 1;
        @(negedge clk);
        chk("stop_req_drop", 32'(dmem_req), 32'd0);
        cyc();
        stop = 0;
        chk("stop_idle", 32'(state), 32'(S_IDLE));
        chk("stop_ir_kept", inst, I_SW);
        cyc();

        // HLT parks the core until stop; pause is ignored there.
        imem_rdata = I_HLT; imem_ready = 1;
        cyc();
        imem_ready = 0;
        @(negedge clk);
        chk("hlt_state_id", 32'(state), 32'(S_ID));
        chk("hlt_strobe", 32'(hlt), 32'd1);
        chk("hlt_next", 32'(next), 32'd1);
        cyc();
        for (int k = 0; k < 20; k++) begin
            pause = (k >= 5 && k < 9);
            @(negedge clk);
            chk("halt_state", 32'(state), 32'(S_HALT));
            chk("halt_outs_zero", 32'(|all_outs), 32'd0);
            cyc();
        end
        pause = 0;
        stop = 1;
        cyc();
        stop = 0;
        chk("halt_stop_idle", 32'(state), 32'(S_IDLE));
        cyc();
        @(negedge clk);
        chk("halt_restart_if", 32'(state), 32'(S_IF));
        chk("halt_restart_req", 32'(imem_req), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
